// File: rtl/stream_ctrl_pkg.sv
// Shared types and constants for the stream flow controller.
// The optional PREFILL timeout is enabled with STREAM_CTRL_TIMEOUT_EN.
package stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam int unsigned UNDERRUN_CNT_W = 8;
  localparam logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT_MAX = '1;

endpackage

// File: rtl/stream_ctrl_if.sv
// Control/status bundle between the stream controller, the RX FIFO and the modulator.
// master = environment side (FIFO + modulator), slave = stream_ctrl.
interface stream_ctrl_if #(
  parameter int DEPTH_WIDTH = 10
) ();
  import stream_ctrl_pkg::*;

  logic                      start;
  logic                      stop;
  logic                      fifo_wr_en;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      mod_read;
  logic                      fifo_rd_en;
  logic                      mod_enable;
  logic [DEPTH_WIDTH:0]      level;
  logic [1:0]                state;
  logic                      underrun;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt;

  modport master (
    output start, stop, fifo_wr_en, fifo_full, fifo_empty, mod_read,
    input  fifo_rd_en, mod_enable, level, state, underrun, underrun_cnt
  );

  modport slave (
    input  start, stop, fifo_wr_en, fifo_full, fifo_empty, mod_read,
    output fifo_rd_en, mod_enable, level, state, underrun, underrun_cnt
  );

endinterface

// File: rtl/stream_ctrl_fifo_level_tracker.sv
// Up/down occupancy counter that mirrors a FIFO from its applied strobes.
// Saturates at 0 and 2^DEPTH_WIDTH; simultaneous inc/dec cancel.
module fifo_level_tracker #(
  parameter int DEPTH_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [DEPTH_WIDTH:0] level_o
);

  localparam logic [DEPTH_WIDTH:0] LEVEL_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [DEPTH_WIDTH:0] level_q, level_d;

  // Clamps are defensive only: qualified strobes should never push past the ends.
  always_comb begin
    level_d = level_q;
    if (inc_i && !dec_i && (level_q != LEVEL_MAX)) begin
      level_d = level_q + 1'b1;
    end else if (dec_i && !inc_i && (level_q != '0)) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/stream_ctrl.sv
// Flow controller between the USB RX FIFO and the modulator: prefill, run, underrun re-buffer, drain.
// Define STREAM_CTRL_TIMEOUT_EN to force PREFILL -> RUN after TIMEOUT_CYCLES without writes.
//
// state   | meaning
// IDLE    | stopped, modulator off
// PREFILL | buffering up to the watermark, modulator off
// RUN     | streaming, reads forwarded to the FIFO
// DRAIN   | stop requested, emptying the FIFO
module stream_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int DEPTH_WIDTH    = 10,
  parameter int PREFILL_LEVEL  = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          rst_n,
  stream_ctrl_if.slave bus
);

  localparam logic [DEPTH_WIDTH:0] PREFILL_LVL = (DEPTH_WIDTH+1)'(PREFILL_LEVEL);

  state_e                    state_q, state_d;
  logic                      mod_enable_q, mod_enable_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;
  logic [DEPTH_WIDTH:0]      level;
  logic                      rd_en;
  logic                      timeout_hit;

  assign rd_en = bus.mod_read & mod_enable_q & ~bus.fifo_empty;

  fifo_level_tracker #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_level (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (bus.fifo_wr_en),
    .dec_i   (rd_en),
    .level_o (level)
  );

`ifdef STREAM_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero outside PREFILL, so entering PREFILL always starts a fresh window.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q != ST_PREFILL) || bus.fifo_wr_en) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_LIMIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timeout_hit = (tmo_cnt_q == TMO_LIMIT) && (level != '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if ((level >= PREFILL_LVL) || bus.fifo_full || timeout_hit) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop takes priority over a coincident underrun
        if (bus.stop) begin
          state_d = ST_DRAIN;
        end else if (bus.mod_read && bus.fifo_empty) begin
          state_d    = ST_PREFILL;
          underrun_d = 1'b1;
          if (underrun_cnt_q != UNDERRUN_CNT_MAX) underrun_cnt_d = underrun_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.start && !bus.stop) begin
          state_d = ST_RUN;
        end else if (bus.fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mod_enable_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mod_enable_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      mod_enable_q   <= mod_enable_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign bus.fifo_rd_en   = rd_en;
  assign bus.mod_enable   = mod_enable_q;
  assign bus.level        = level;
  assign bus.state        = state_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_stream_ctrl.sv
// Self-checking bench for stream_ctrl: directed scenarios plus a randomized run against a reference model.
// Honours STREAM_CTRL_TIMEOUT_EN the same way as the design.
module tb_stream_ctrl;

  localparam int DW   = 10;
  localparam int PL   = 512;
  localparam int TO   = 1024;
  localparam int LMAX = 1 << DW;

  localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_ctrl_if #(.DEPTH_WIDTH(DW)) sif ();

  stream_ctrl #(
    .DEPTH_WIDTH    (DW),
    .PREFILL_LEVEL  (PL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state, m_level, m_ucnt, m_idle;
  bit m_en, m_pulse;

  task automatic model_reset();
    m_state = M_IDLE; m_level = 0; m_ucnt = 0; m_idle = 0; m_en = 0; m_pulse = 0;
  endtask

  task automatic drive(input bit st, input bit sp, input bit wr, input bit full,
                       input bit emp, input bit mr);
    sif.start = st; sif.stop = sp; sif.fifo_wr_en = wr & ~full;
    sif.fifo_full = full; sif.fifo_empty = emp; sif.mod_read = mr;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic step();
    bit rd;
    int nl, ns, nc, ni;
    bit np;
    rd = sif.mod_read && m_en && !sif.fifo_empty;
    nl = m_level;
    if (sif.fifo_wr_en && !rd && nl < LMAX) nl = nl + 1;
    else if (rd && !sif.fifo_wr_en && nl > 0) nl = nl - 1;
    ns = m_state; np = 0; nc = m_ucnt;
    case (m_state)
      M_IDLE:  if (sif.start && !sif.stop) ns = M_PRE;
      M_PRE: begin
        if (sif.stop) ns = M_IDLE;
        else if (m_level >= PL || sif.fifo_full) ns = M_RUN;
`ifdef STREAM_CTRL_TIMEOUT_EN
        else if (m_idle >= TO && m_level > 0) ns = M_RUN;
`endif
      end
      M_RUN: begin
        if (sif.stop) ns = M_DRAIN;
        else if (sif.mod_read && sif.fifo_empty) begin
          ns = M_PRE; np = 1;
          if (nc < 255) nc = nc + 1;
        end
      end
      default: begin
        if (sif.start && !sif.stop) ns = M_RUN;
        else if (sif.fifo_empty) ns = M_IDLE;
      end
    endcase
    ni = (m_state == M_PRE && !sif.fifo_wr_en) ? m_idle + 1 : 0;
    @(posedge clk);
    #1;
    m_state = ns; m_level = nl; m_ucnt = nc; m_pulse = np; m_idle = ni;
    m_en = (ns == M_RUN) || (ns == M_DRAIN);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    sif.mod_read = 1'b1; sif.fifo_empty = 1'b0;
    #2;
    checks++; if (sif.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", sif.state); end
    checks++; if (sif.level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", sif.level); end
    checks++; if (sif.mod_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", sif.mod_enable); end
    checks++; if (sif.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", sif.underrun); end
    checks++; if (sif.underrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_ucnt got %0d want 0", sif.underrun_cnt); end
    checks++; if (sif.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", sif.fifo_rd_en); end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_prefill();
    drive(1, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 511; i++) begin drive(0, 0, 1, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    checks++; if (sif.state !== 2'd1) begin errors++; $display("FAIL prefill_511_state got %0d want 1", sif.state); end
    checks++; if (sif.mod_enable !== 1'b0) begin errors++; $display("FAIL prefill_511_en got %b want 0", sif.mod_enable); end
    checks++; if (sif.level !== 11'd511) begin errors++; $display("FAIL prefill_511_level got %0d want 511", sif.level); end
    drive(0, 0, 1, 0, 0, 0); step();
    checks++; if (sif.state !== 2'd1 || sif.level !== 11'd512) begin
      errors++; $display("FAIL prefill_512_edge got state %0d level %0d want 1/512", sif.state, sif.level); end
    drive(0, 0, 0, 0, 0, 0); step();
    checks++; if (sif.state !== 2'd2 || sif.mod_enable !== 1'b1) begin
      errors++; $display("FAIL prefill_run got state %0d en %b want 2/1", sif.state, sif.mod_enable); end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 212; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end
    checks++; if (sif.level !== 11'd300) begin errors++; $display("FAIL conc_pre_level got %0d want 300", sif.level); end
    drive(0, 0, 1, 0, 0, 1); #2;
    checks++; if (sif.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL conc_rd_en got %b want 1", sif.fifo_rd_en); end
    step();
    checks++; if (sif.level !== 11'd300) begin errors++; $display("FAIL conc_level got %0d want 300", sif.level); end
    drive(0, 0, 1, 0, 1, 1); #2;
    checks++; if (sif.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL conc_rd_en_empty got %b want 0", sif.fifo_rd_en); end
    step();
    checks++; if (sif.level !== 11'(m_level) || sif.state !== 2'(m_state) || sif.underrun !== 1'b1) begin
      errors++; $display("FAIL conc_underrun got lvl %0d st %0d ur %b want %0d/%0d/1",
                         sif.level, sif.state, sif.underrun, m_level, m_state); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_underrun();
    int base;
    base = m_ucnt;
    for (int i = 1; i <= 300; i++) begin
      drive(0, 0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 0, 1, 1);
      if (i == 1) begin
        #2;
        checks++; if (sif.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL ur_rd_en got %b want 0", sif.fifo_rd_en); end
      end
      step();
      checks++; if (sif.underrun_cnt !== 8'((base + i > 255) ? 255 : base + i)) begin
        errors++; $display("FAIL ur_cnt iter %0d got %0d want %0d", i, sif.underrun_cnt, (base + i > 255) ? 255 : base + i); end
      if (i == 1) begin
        checks++; if (sif.underrun !== 1'b1 || sif.state !== 2'd1) begin
          errors++; $display("FAIL ur_pulse got ur %b st %0d want 1/1", sif.underrun, sif.state); end
        drive(0, 0, 0, 0, 0, 0); step();
        checks++; if (sif.underrun !== 1'b0) begin errors++; $display("FAIL ur_pulse_width got %b want 0", sif.underrun); end
      end
    end
    checks++; if (sif.underrun_cnt !== 8'd255) begin errors++; $display("FAIL ur_sat got %0d want 255", sif.underrun_cnt); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stop_drain();
    drive(0, 0, 0, 1, 0, 0); step();
    while (m_level > 10) begin drive(0, 0, 0, 0, 0, 1); step(); end
    while (m_level < 10) begin drive(0, 0, 1, 0, 0, 0); step(); end
    drive(0, 1, 0, 0, 0, 0); step();
    checks++; if (sif.state !== 2'd3 || sif.level !== 11'd10) begin
      errors++; $display("FAIL drain_enter got st %0d lvl %0d want 3/10", sif.state, sif.level); end
    for (int i = 0; i < 10; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end
    checks++; if (sif.state !== 2'd3 || sif.level !== 11'd0) begin
      errors++; $display("FAIL drain_reads got st %0d lvl %0d want 3/0", sif.state, sif.level); end
    drive(0, 0, 0, 0, 1, 0); step();
    checks++; if (sif.state !== 2'd0 || sif.mod_enable !== 1'b0) begin
      errors++; $display("FAIL drain_idle got st %0d en %b want 0/0", sif.state, sif.mod_enable); end
    drive(1, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0); step();
    checks++; if (sif.state !== 2'd3 || sif.mod_enable !== 1'b1) begin
      errors++; $display("FAIL start_stop_run got st %0d en %b want 3/1", sif.state, sif.mod_enable); end
    drive(0, 0, 0, 0, 1, 0); step();
  endtask

  task automatic test_timeout();
    int n, bad;
    do_reset();
    drive(1, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0);
`ifdef STREAM_CTRL_TIMEOUT_EN
    n = 0; bad = 0;
    while (sif.state !== 2'd2 && n < 1100) begin
      step(); n++;
      if (sif.state !== 2'(m_state)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tmo_model got %0d cycle mismatches want 0", bad); end
    checks++; if (sif.state !== 2'd2 || n < TO || n > TO + 2) begin
      errors++; $display("FAIL tmo_run got st %0d after %0d idle cycles want 2 after ~%0d", sif.state, n, TO); end
`else
    n = 0; bad = 0;
    for (int i = 0; i < 5000; i++) begin step(); n++; end
    checks++; if (sif.state !== 2'd1 || sif.mod_enable !== 1'b0) begin
      errors++; $display("FAIL no_tmo got st %0d en %b after %0d cycles want 1/0", sif.state, sif.mod_enable, n); end
    checks++; if (sif.level !== 11'd5) begin errors++; $display("FAIL no_tmo_level got %0d want 5", sif.level); end
`endif
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    drive(1, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    for (int i = 0; i < 700; i++) begin drive(0, 0, 1, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (sif.level !== 11'd700 || sif.state !== 2'd2) begin
      errors++; $display("FAIL mid_pre got lvl %0d st %0d want 700/2", sif.level, sif.state); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (sif.level !== '0 || sif.state !== 2'd0 || sif.mod_enable !== 1'b0) begin
      errors++; $display("FAIL mid_reset got lvl %0d st %0d en %b want 0/0/0", sif.level, sif.state, sif.mod_enable); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit st, sp, wr, full, emp, mr, exp_rd;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      st   = ($urandom_range(15) == 0);
      sp   = ($urandom_range(31) == 0);
      wr   = $urandom_range(1);
      full = (m_level == LMAX) || ($urandom_range(63) == 0);
      emp  = (m_level == 0) || ($urandom_range(15) == 0);
      mr   = $urandom_range(1);
      drive(st, sp, wr, full, emp, mr);
      #2;
      exp_rd = mr && m_en && !emp;
      checks++; if (sif.fifo_rd_en !== exp_rd) begin
        errors++; $display("FAIL rnd_rd_en cyc %0d got %b want %b", c, sif.fifo_rd_en, exp_rd); end
      step();
      checks++; if (sif.state !== 2'(m_state) || sif.level !== 11'(m_level) || sif.mod_enable !== m_en ||
                    sif.underrun !== m_pulse || sif.underrun_cnt !== 8'(m_ucnt)) begin
        errors++; $display("FAIL rnd_regs cyc %0d got st %0d lvl %0d en %b ur %b cnt %0d want %0d/%0d/%b/%b/%0d",
                           c, sif.state, sif.level, sif.mod_enable, sif.underrun, sif.underrun_cnt,
                           m_state, m_level, m_en, m_pulse, m_ucnt); end
    end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 1, 0);
    test_reset();
    test_prefill();
    test_concurrent();
    test_underrun();
    test_stop_drain();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
